// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock, LSB first,
// using one full-subtractor cell and a borrow flop. Start/ready in, valid pulse out.
module serial_subtractor #(
    parameter int N_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_WIDTH-1:0] a,
    input  logic [N_WIDTH-1:0] b,
    input  logic               b_in,
    output logic               ready,
    output logic [N_WIDTH-1:0] diff,
    output logic               b_out,
    output logic               valid
);

    localparam int CNT_W = ($clog2(N_WIDTH + 1) < 1) ? 1 : $clog2(N_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic c);
        full_sub = {(~x & y) | (~(x ^ y) & c), x ^ y ^ c};
    endfunction

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_WIDTH-1:0] a_sr_q;
    logic [N_WIDTH-1:0] b_sr_q;
    logic [N_WIDTH-1:0] res_sr_q;
    logic               borrow_q;
    logic [N_WIDTH-1:0] diff_q;
    logic               b_out_q;
    logic               valid_q;
    logic               ready_q;

    logic [1:0]         bit_d;
    logic [N_WIDTH-1:0] res_d;
    logic               last_s;

    // Subtractor cell and the result register with this edge's bit inserted at the MSB.
    always_comb begin
        bit_d              = full_sub(a_sr_q[0], b_sr_q[0], borrow_q);
        res_d              = res_sr_q >> 1;
        res_d[N_WIDTH-1]   = bit_d[0];
        last_s             = (cnt_q == CNT_W'(N_WIDTH - 1));
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        borrow_q <= b_in;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_sr_q <= res_d;
                    borrow_q <= bit_d[1];
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_s) begin
                        diff_q  <= res_d;
                        b_out_q <= bit_d[1];
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at N_WIDTH = 4, 1 and 16 against an
// arithmetic reference model (a - b - b_in).
module tb_serial_subtractor;

    logic clk;
    logic rst_n;

    logic        start4, bin4, ready4, bout4, valid4;
    logic [3:0]  a4, b4, diff4;
    logic        start1, bin1, ready1, bout1, valid1;
    logic [0:0]  a1, b1, diff1;
    logic        start16, bin16, ready16, bout16, valid16;
    logic [15:0] a16, b16, diff16;

    int n_cmp;
    int n_fail;

    serial_subtractor #(.N_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .b_in(bin4),
        .ready(ready4), .diff(diff4), .b_out(bout4), .valid(valid4)
    );
    serial_subtractor #(.N_WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .b_in(bin1),
        .ready(ready1), .diff(diff1), .b_out(bout1), .valid(valid1)
    );
    serial_subtractor #(.N_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .b_in(bin16),
        .ready(ready16), .diff(diff16), .b_out(bout16), .valid(valid16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation on the 4-bit instance; lat counts edges from accept to valid.
    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                       output logic [3:0] rd, output logic rbo, output int lat);
        @(negedge clk);
        while (!ready4) @(negedge clk);
        a4 = ta; b4 = tb; bin4 = tbin; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        lat = 0;
        while (!valid4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = diff4; rbo = bout4;
    endtask

    task automatic op1(input logic ta, input logic tb, input logic tbin,
                       output logic rd, output logic rbo, output int lat);
        @(negedge clk);
        while (!ready1) @(negedge clk);
        a1 = ta; b1 = tb; bin1 = tbin; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = ~ta; b1 = ~tb; bin1 = ~tbin;
        lat = 0;
        while (!valid1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = diff1[0]; rbo = bout1;
    endtask

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                        output logic [15:0] rd, output logic rbo, output int lat);
        @(negedge clk);
        while (!ready16) @(negedge clk);
        a16 = ta; b16 = tb; bin16 = tbin; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
        lat = 0;
        while (!valid16 && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = diff16; rbo = bout16;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_cmp++;
        if ({ready4, diff4, bout4, valid4} !== {1'b1, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset4: got rdy=%b diff=%h bo=%b v=%b want 1 0 0 0", ready4, diff4, bout4, valid4);
        end
        n_cmp++;
        if ({ready1, diff1, bout1, valid1} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset1: got rdy=%b diff=%h bo=%b v=%b want 1 0 0 0", ready1, diff1, bout1, valid1);
        end
        n_cmp++;
        if ({ready16, diff16, bout16, valid16} !== {1'b1, 16'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset16: got rdy=%b diff=%h bo=%b v=%b want 1 0 0 0", ready16, diff16, bout16, valid16);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n_cmp++;
        if (ready4 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ready_fall: got %b want 0", ready4);
        end
        begin
            int lat;
            lat = 0;
            while (!valid4 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            n_cmp++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL basic_latency: got %0d edges want 4", lat);
            end
        end
        n_cmp++;
        if ({diff4, bout4} !== {4'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got diff=%h bo=%b want 6 0", diff4, bout4);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({ready4, valid4} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_after: got rdy=%b v=%b want 1 0", ready4, valid4);
        end
    endtask

    task automatic test_borrow();
        logic [3:0] va [3] = '{4'd3, 4'd0, 4'd15};
        logic [3:0] vb [3] = '{4'd9, 4'd0, 4'd15};
        logic       vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] ed [3] = '{4'hA, 4'hF, 4'hF};
        for (int i = 0; i < 3; i++) begin
            logic [3:0] rd;
            logic       rbo;
            int         lat;
            op4(va[i], vb[i], vc[i], rd, rbo, lat);
            n_cmp++;
            if ({rd, rbo, lat} !== {ed[i], 1'b1, 32'd4}) begin
                n_fail++;
                $display("FAIL borrow_%0d: got diff=%h bo=%b lat=%0d want %h 1 4", i, rd, rbo, lat, ed[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [8:0] q[$];
        logic [3:0] exp_hold;
        int         last_v;
        int         n_valid;
        exp_hold = 4'hF;
        last_v   = -1;
        n_valid  = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            start4 = (i < 60);
            a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
            if (start4 && ready4) q.push_back({a4, b4, bin4});
            @(posedge clk); #1;
            if (valid4) begin
                logic [8:0]  op;
                logic [31:0] full;
                logic        ebo;
                n_valid++;
                op   = (q.size() > 0) ? q.pop_front() : 9'h0;
                full = {28'h0, op[8:5]} - {28'h0, op[4:1]} - {31'h0, op[0]};
                ebo  = (int'(op[8:5]) < int'(op[4:1]) + int'(op[0]));
                exp_hold = full[3:0];
                n_cmp++;
                if ({diff4, bout4} !== {full[3:0], ebo}) begin
                    n_fail++;
                    $display("FAIL b2b_result: got diff=%h bo=%b want %h %b", diff4, bout4, full[3:0], ebo);
                end
                if (last_v >= 0) begin
                    n_cmp++;
                    if (i - last_v !== 6) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d cycles want 6", i - last_v);
                    end
                end
                last_v = i;
            end
            n_cmp++;
            if (diff4 !== exp_hold) begin
                n_fail++;
                $display("FAIL b2b_hold: got diff=%h want %h", diff4, exp_hold);
            end
        end
        start4 = 1'b0;
        n_cmp++;
        if (q.size() !== 0 || n_valid < 9) begin
            n_fail++;
            $display("FAIL b2b_count: got pending=%0d valids=%0d want 0 and >=9", q.size(), n_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] rd;
        logic       rbo;
        int         lat;
        int         seen;
        op4(4'd9, 4'd1, 1'b0, rd, rbo, lat);
        @(negedge clk);
        while (!ready4) @(negedge clk);
        a4 = 4'd12; b4 = 4'd5; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({diff4, bout4, valid4, ready4} !== {4'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_outputs: got diff=%h bo=%b v=%b rdy=%b want 0 0 0 1", diff4, bout4, valid4, ready4);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (valid4) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midrst_novalid: got %0d valids want 0", seen);
        end
        op4(4'd12, 4'd5, 1'b0, rd, rbo, lat);
        n_cmp++;
        if ({rd, rbo, lat} !== {4'd7, 1'b0, 32'd4}) begin
            n_fail++;
            $display("FAIL midrst_retry: got diff=%h bo=%b lat=%0d want 7 0 4", rd, rbo, lat);
        end
    endtask

    task automatic test_n1();
        for (int i = 0; i < 8; i++) begin
            logic ta, tb, tc, rd, rbo, ed, ebo;
            int   lat;
            ta  = i[2]; tb = i[1]; tc = i[0];
            ed  = ((int'(ta) - int'(tb) - int'(tc)) % 2) != 0;
            ebo = int'(ta) < int'(tb) + int'(tc);
            op1(ta, tb, tc, rd, rbo, lat);
            n_cmp++;
            if ({rd, rbo, lat} !== {ed, ebo, 32'd1}) begin
                n_fail++;
                $display("FAIL n1_%0d: got diff=%b bo=%b lat=%0d want %b %b 1", i, rd, rbo, lat, ed, ebo);
            end
        end
    endtask

    task automatic test_n16();
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ta, tb, rd;
            logic        tc, rbo, ebo;
            logic [31:0] full;
            int          lat;
            ta   = 16'($urandom); tb = 16'($urandom); tc = 1'($urandom);
            if (i == 0) begin ta = 16'h0; tb = 16'hFFFF; tc = 1'b1; end
            if (i == 1) begin ta = 16'hFFFF; tb = 16'h0; tc = 1'b0; end
            full = {16'h0, ta} - {16'h0, tb} - {31'h0, tc};
            ebo  = int'(ta) < int'(tb) + int'(tc);
            op16(ta, tb, tc, rd, rbo, lat);
            n_cmp++;
            if ({rd, rbo, lat} !== {full[15:0], ebo, 32'd16}) begin
                n_fail++;
                $display("FAIL n16_%0d: got diff=%h bo=%b lat=%0d want %h %b 16", i, rd, rbo, lat, full[15:0], ebo);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        start16 = 1'b0; a16 = 16'h0; b16 = 16'h0; bin16 = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_reset_mid_run();
        test_n1();
        test_n16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes diff = a - b - b_in, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop.
- Companion to the parallel ripple adder in the arithmetic library. It is the inverse operation, built for area-constrained datapaths where N_WIDTH cycles of latency is acceptable.
- Operands are accepted with a start/ready handshake. The result is reported with a one-cycle valid pulse.

Parameters:
- N_WIDTH, 4, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a subtraction; sampled only when ready=1
- a  input  N_WIDTH  minuend; captured on the accepting edge
- b  input  N_WIDTH  subtrahend; captured on the accepting edge
- b_in  input  1  borrow in; captured on the accepting edge
- ready  output  1  high only in IDLE; block can accept start
- diff  output  N_WIDTH  result (a - b - b_in) mod 2^N_WIDTH
- b_out  output  1  borrow out; 1 iff a < b + b_in (unsigned)
- valid  output  1  one-cycle pulse; diff and b_out are new this cycle

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: ready=1, diff=0, b_out=0, valid=0, FSM=IDLE, bit counter=0, internal shift and borrow registers=0.
- Reset is effective immediately on rst_n low, regardless of clk.
- FSM states:
  - IDLE: ready=1. Moves to RUN on an edge with start=1.
  - RUN: ready=0. Stays for exactly N_WIDTH edges.
  - DONE: ready=0, valid=1 for exactly one cycle. Returns to IDLE on the next edge.
- Accept edge (IDLE, start=1):
  - Load the a and b shift registers.
  - Load borrow register from b_in.
  - Clear the bit counter.
- Each RUN edge, with x = a_sr[0], y = b_sr[0], c = borrow:
  - d = x^y^c
  - borrow <= (~x & y) | (~(x^y) & c)
  - Shift a_sr and b_sr right by 1.
  - Shift d into the MSB of the result shift register.
  - Increment the counter.
- On the RUN edge where counter == N_WIDTH-1 (the Nth bit):
  - FSM goes to DONE.
  - diff <= final result shift register contents, including this edge's bit.
  - b_out <= final borrow.
  - valid <= 1.
- Latency: start sampled at edge T0 gives valid=1 in the cycle following edge T(N_WIDTH). Throughput is one operation per N_WIDTH+2 cycles.
- diff and b_out hold their value from the last completed operation until the next DONE. They never show intermediate bits.
- start is ignored while in RUN or DONE. No queuing; no error flag.
- a, b and b_in may change freely after the accept edge without affecting the result.
- N_WIDTH=1: RUN lasts one edge; otherwise identical behaviour.
- Wrap-around: diff is modulo 2^N_WIDTH. Underflow is indicated solely by b_out.
- Reset mid-RUN or in DONE:
  - Operation is abandoned; no valid is produced.
  - All outputs return to reset values, including diff=0.
  - ready=1 while rst_n is low and after release.
- Counter width: clog2(N_WIDTH+1) bits, minimum 1.

Test Plan:
- N_WIDTH=4, a=9, b=3, b_in=0, start pulse in IDLE -> ready falls the next cycle; valid high exactly 5 cycles after the accept edge; diff=6, b_out=0; ready=1 the cycle after valid.
- N_WIDTH=4, a=3, b=9, b_in=0 -> diff=4'hA, b_out=1. Then a=0, b=0, b_in=1 -> diff=4'hF, b_out=1. Then a=15, b=15, b_in=1 -> diff=4'hF, b_out=1.
- Start held high continuously with random operands changing every cycle -> an operation is accepted only in IDLE cycles. Each result matches the operands captured on its accept edge, one valid per N_WIDTH+2 cycles. diff is stable between valids.
- Assert rst_n=0 asynchronously (mid-clock) during the 2nd RUN cycle of a=12, b=5 -> outputs immediately reset (diff=0, b_out=0, valid=0, ready=1); no valid after release. A new 12-5 then yields diff=7, b_out=0.
- N_WIDTH=1: exhaustive a, b, b_in in {0,1} -> {diff, b_out} matches the truth table of a 1-bit full subtractor; valid 2 cycles after accept.
- N_WIDTH=16: 1000 random operands vs reference model (a - b - b_in) -> diff and b_out match for every transaction; 17-cycle latency each.
